// File: rtl/rp_8bit_bd_arb.sv
// rp_8bit_bd_arb: two-port arbiter sharing one synchronous data SRAM.
// Port 0 (CPU data bus) has fixed priority. Port 1 (debug/DMA) is forced to
// win after MAXWAIT lost conflicts. Addresses at or above DSZ complete with
// an error and never reach the memory.
module rp_8bit_bd_arb #(
  parameter int DAW     = 13,
  parameter int DW      = 8,
  parameter int DSZ     = 2**DAW,
  parameter int MAXWAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           p0_req,
  input  logic           p0_wen,
  input  logic [DAW-1:0] p0_adr,
  input  logic [DW-1:0]  p0_wdt,
  output logic [DW-1:0]  p0_rdt,
  output logic           p0_ack,
  output logic           p0_err,
  input  logic           p1_req,
  input  logic           p1_wen,
  input  logic [DAW-1:0] p1_adr,
  input  logic [DW-1:0]  p1_wdt,
  output logic [DW-1:0]  p1_rdt,
  output logic           p1_ack,
  output logic           p1_err,
  output logic           m_ena,
  output logic           m_wen,
  output logic [DAW-1:0] m_adr,
  output logic [DW-1:0]  m_wdt,
  input  logic [DW-1:0]  m_rdt
);

  localparam int WCW = 4;
  localparam logic [WCW-1:0] WMAX  = WCW'(MAXWAIT);
  // One extra bit so DSZ == 2**DAW is representable.
  localparam logic [DAW:0]   DSZ_L = (DAW+1)'(DSZ);

  logic           gv;
  logic           gs;
  logic           ge;
  logic [WCW-1:0] wcnt;

  logic           p0_elig;
  logic           p1_elig;
  logic           gnt_v;
  logic           gnt_s;
  logic           sel_wen;
  logic [DAW-1:0] sel_adr;
  logic [DW-1:0]  sel_wdt;
  logic           in_range;

  // A request that is still high in its own ack cycle is already served.
  assign p0_ack  = gv & ~gs;
  assign p1_ack  = gv &  gs;
  assign p0_elig = p0_req & ~p0_ack;
  assign p1_elig = p1_req & ~p1_ack;

  // Fixed priority for port 0 unless port 1 has lost MAXWAIT conflicts.
  always_comb begin
    gnt_v = p0_elig | p1_elig;
    gnt_s = p1_elig & (~p0_elig | (wcnt == WMAX));
  end

  // Payload mux and range check on the granted address.
  always_comb begin
    sel_wen  = gnt_s ? p1_wen : p0_wen;
    sel_adr  = gnt_s ? p1_adr : p0_adr;
    sel_wdt  = gnt_s ? p1_wdt : p0_wdt;
    in_range = ({1'b0, sel_adr} < DSZ_L);
  end

  // Memory strobes are held off during reset and for out-of-range grants.
  always_comb begin
    m_ena = gnt_v & in_range & ~rst;
    m_wen = m_ena & sel_wen;
    m_adr = sel_adr;
    m_wdt = sel_wdt;
  end

  // Completion side: ack/err one cycle after grant, read data gated by ack.
  always_comb begin
    p0_err = p0_ack & ge;
    p1_err = p1_ack & ge;
    p0_rdt = (p0_ack & ~ge) ? m_rdt : '0;
    p1_rdt = (p1_ack & ~ge) ? m_rdt : '0;
  end

  // Grant registers; a pending ack is dropped by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gv <= 1'b0;
      gs <= 1'b0;
      ge <= 1'b0;
    end else begin
      gv <= gnt_v;
      gs <= gnt_s;
      ge <= gnt_v & ~in_range;
    end
  end

  // Port 1 starvation counter; saturation follows from port 1 winning at WMAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (gnt_v & gnt_s) begin
      wcnt <= '0;
    end else if (p0_elig & p1_elig & (wcnt != WMAX)) begin
      wcnt <= wcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rp_8bit_bd_arb.sv
// Directed bench for rp_8bit_bd_arb with a behavioural synchronous SRAM.
module tb_rp_8bit_bd_arb;

  localparam int DAW = 13;
  localparam int DW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           p0_req, p0_wen, p1_req, p1_wen;
  logic [DAW-1:0] p0_adr, p1_adr;
  logic [DW-1:0]  p0_wdt, p1_wdt;
  logic [DW-1:0]  p0_rdt, p1_rdt;
  logic           p0_ack, p0_err, p1_ack, p1_err;
  logic           m_ena, m_wen;
  logic [DAW-1:0] m_adr;
  logic [DW-1:0]  m_wdt, m_rdt;

  // Second instance with a 4096-word memory for the range boundary.
  logic [DW-1:0]  s_p0_rdt, s_p1_rdt;
  logic           s_p0_ack, s_p0_err, s_p1_ack, s_p1_err;
  logic           s_m_ena, s_m_wen;
  logic [DAW-1:0] s_m_adr;
  logic [DW-1:0]  s_m_wdt;
  logic [DW-1:0]  s_m_rdt = 8'hFF;

  logic [DW-1:0]  mem [0:(1<<DAW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rp_8bit_bd_arb #(.DAW(DAW), .DW(DW), .DSZ(8192), .MAXWAIT(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wen(p0_wen), .p0_adr(p0_adr), .p0_wdt(p0_wdt),
    .p0_rdt(p0_rdt), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_wen(p1_wen), .p1_adr(p1_adr), .p1_wdt(p1_wdt),
    .p1_rdt(p1_rdt), .p1_ack(p1_ack), .p1_err(p1_err),
    .m_ena(m_ena), .m_wen(m_wen), .m_adr(m_adr), .m_wdt(m_wdt), .m_rdt(m_rdt)
  );

  rp_8bit_bd_arb #(.DAW(DAW), .DW(DW), .DSZ(4096), .MAXWAIT(4)) dut_s (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wen(p0_wen), .p0_adr(p0_adr), .p0_wdt(p0_wdt),
    .p0_rdt(s_p0_rdt), .p0_ack(s_p0_ack), .p0_err(s_p0_err),
    .p1_req(p1_req), .p1_wen(p1_wen), .p1_adr(p1_adr), .p1_wdt(p1_wdt),
    .p1_rdt(s_p1_rdt), .p1_ack(s_p1_ack), .p1_err(s_p1_err),
    .m_ena(s_m_ena), .m_wen(s_m_wen), .m_adr(s_m_adr), .m_wdt(s_m_wdt),
    .m_rdt(s_m_rdt)
  );

  // Synchronous SRAM: read data valid the cycle after m_ena.
  always @(posedge clk) begin
    if (m_ena) begin
      if (m_wen) mem[m_adr] <= m_wdt;
      else       m_rdt <= mem[m_adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 0; p0_wen = 0; p0_adr = '0; p0_wdt = '0;
    p1_req = 0; p1_wen = 0; p1_adr = '0; p1_wdt = '0;
    m_rdt = '0;
    for (int i = 0; i < (1<<DAW); i++) mem[i] = 8'h00;
    mem[13'h0010] = 8'hA5;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_p0_ack", p0_ack, 0);
    chk("rst_p1_ack", p1_ack, 0);
    chk("rst_p0_err", p0_err, 0);
    chk("rst_p0_rdt", p0_rdt, 0);
    chk("rst_m_ena",  m_ena,  0);
    chk("rst_wcnt",   dut.wcnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single read on port 0
    @(posedge clk); #1 p0_req = 1; p0_wen = 0; p0_adr = 13'h0010;
    @(negedge clk);
    chk("rd_m_ena", m_ena, 1);
    chk("rd_m_adr", m_adr, 13'h0010);
    chk("rd_m_wen", m_wen, 0);
    @(posedge clk); #1 p0_req = 0;
    @(negedge clk);
    chk("rd_p0_ack", p0_ack, 1);
    chk("rd_p0_rdt", p0_rdt, 8'hA5);
    chk("rd_p0_err", p0_err, 0);
    @(negedge clk);
    chk("rd_ack_pulse", p0_ack, 0);

    // Port 1 write then read back
    @(posedge clk); #1 p1_req = 1; p1_wen = 1; p1_adr = 13'h1F00; p1_wdt = 8'h3C;
    @(negedge clk);
    chk("wr_m_ena", m_ena, 1);
    chk("wr_m_wen", m_wen, 1);
    chk("wr_m_wdt", m_wdt, 8'h3C);
    @(posedge clk); #1 p1_req = 0;
    @(negedge clk);
    chk("wr_p1_ack", p1_ack, 1);
    chk("wr_p1_err", p1_err, 0);
    chk("wr_p0_ack", p0_ack, 0);
    @(posedge clk); #1 p1_req = 1; p1_wen = 0;
    @(negedge clk);
    chk("rb_m_wen", m_wen, 0);
    @(posedge clk); #1 p1_req = 0;
    @(negedge clk);
    chk("rb_p1_ack", p1_ack, 1);
    chk("rb_p1_rdt", p1_rdt, 8'h3C);
    chk("rb_p0_ack", p0_ack, 0);
    chk("rb_p0_rdt", p0_rdt, 0);

    // Conflicts: p0 holds req; p1 only requests when p0 is eligible
    @(posedge clk); #1 p0_req = 1; p0_wen = 0; p0_adr = 13'h0020;
    p1_adr = 13'h0030; p1_wen = 0;
    for (int k = 0; k < 4; k++) begin
      p1_req = 1;
      @(negedge clk);
      chk("cf_p0_wins", m_adr, 13'h0020);
      @(posedge clk); #1 p1_req = 0;
      @(negedge clk);
      chk("cf_wcnt", dut.wcnt, k + 1);
      chk("cf_p0_ack", p0_ack, 1);
      chk("cf_idle", m_ena, 0);
      @(posedge clk); #1;
    end
    p1_req = 1;
    @(negedge clk);
    chk("cf_p1_wins", m_adr, 13'h0030);
    chk("cf_wcnt_sat", dut.wcnt, 4);
    @(posedge clk); #1 p1_req = 0;
    @(negedge clk);
    chk("cf_p1_ack", p1_ack, 1);
    chk("cf_wcnt_clr", dut.wcnt, 0);
    chk("cf_p0_next", m_adr, 13'h0020);
    @(posedge clk); #1 p0_req = 0;
    @(negedge clk);
    chk("cf_p0_ack_last", p0_ack, 1);

    // Range boundary on the 4096-word instance
    @(posedge clk); #1 p1_req = 1; p1_wen = 0; p1_adr = 13'h1000;
    @(negedge clk);
    chk("oor_m_ena", s_m_ena, 0);
    @(posedge clk); #1 p1_req = 0;
    @(negedge clk);
    chk("oor_p1_ack", s_p1_ack, 1);
    chk("oor_p1_err", s_p1_err, 1);
    chk("oor_p1_rdt", s_p1_rdt, 0);
    @(posedge clk); #1 p1_req = 1; p1_adr = 13'h0FFF;
    @(negedge clk);
    chk("edge_m_ena", s_m_ena, 1);
    @(posedge clk); #1 p1_req = 0;
    @(negedge clk);
    chk("edge_p1_err", s_p1_err, 0);
    chk("edge_p1_rdt", s_p1_rdt, 8'hFF);

    // Reset in the cycle after a p0 grant (conflict so wcnt is non-zero)
    @(posedge clk); #1 p0_req = 1; p0_adr = 13'h0040; p1_req = 1; p1_adr = 13'h0050;
    @(posedge clk); #1 p1_req = 0;
    chk("mr_pre_ack", p0_ack, 1);
    chk("mr_pre_wcnt", dut.wcnt, 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_p0_ack", p0_ack, 0);
    chk("mr_wcnt", dut.wcnt, 0);
    chk("mr_m_ena", m_ena, 0);
    p0_req = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mr_no_ack0", p0_ack, 0);
      chk("mr_no_ack1", p1_ack, 0);
    end

    // Reset inside the grant cycle drops the transfer
    @(posedge clk); #1 p0_req = 1; p0_adr = 13'h0010;
    #2 rst = 1'b1; p0_req = 0;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("drop_no_ack", p0_ack, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
